// File: rtl/alu32_two_pass_sequencer.sv
// Runs one 32-bit ALU operation as two passes (low half, then high half) through a shared
// 16-bit ALU slice, chaining carry between passes and forming 32-bit SLT and zero.
module alu32_two_pass_sequencer #(
    parameter int SLICE_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [2*SLICE_W-1:0]   in_a,
    input  logic [2*SLICE_W-1:0]   in_b,
    output logic [SLICE_W-1:0]     alu_a,
    output logic [SLICE_W-1:0]     alu_b,
    output logic [2:0]             alu_op,
    output logic                   alu_cin,
    output logic                   alu_less,
    input  logic [SLICE_W-1:0]     alu_result,
    input  logic                   alu_cout,
    input  logic                   alu_set,
    input  logic                   alu_zero,
    input  logic                   alu_overflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*SLICE_W-1:0]   out_result,
    output logic                   out_cout,
    output logic                   out_zero,
    output logic                   out_overflow,
    output logic                   out_illegal
);

    localparam int W = 2 * SLICE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [2:0]         op_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [SLICE_W-1:0] res_lo;
    logic               cout_lo;
    logic               zero_lo;

    logic       op_addsub;
    logic       op_slt;
    logic       op_arith;
    logic       op_legal;
    logic [2:0] slice_op;
    logic       lt_hi;

    // Op decode; SLT runs as a subtract, illegal ops run as AND so the passes stay harmless.
    always_comb begin
        op_addsub = (op_r == 3'b010) || (op_r == 3'b110);
        op_slt    = (op_r == 3'b111);
        op_arith  = op_addsub || op_slt;
        op_legal  = op_arith || (op_r == 3'b000) || (op_r == 3'b001);
        if (op_slt)
            slice_op = 3'b110;
        else if (op_legal)
            slice_op = op_r;
        else
            slice_op = 3'b000;
        lt_hi = alu_set ^ alu_overflow;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = 3'b000;
        alu_cin   = 1'b0;
        alu_less  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = LO;
            end
            LO: begin
                alu_a     = a_r[SLICE_W-1:0];
                alu_b     = b_r[SLICE_W-1:0];
                alu_op    = slice_op;
                alu_cin   = op_arith & op_r[2];
                state_nxt = HI;
            end
            HI: begin
                alu_a     = a_r[W-1:SLICE_W];
                alu_b     = b_r[W-1:SLICE_W];
                alu_op    = slice_op;
                alu_cin   = op_arith & cout_lo;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Request and low-pass capture; contents only matter while a request is in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op_r <= in_op;
            a_r  <= in_a;
            b_r  <= in_b;
        end
        if (state == LO) begin
            res_lo  <= alu_result;
            cout_lo <= alu_cout;
            zero_lo <= alu_zero;
        end
    end

    // High-pass capture forms the final 32-bit response, held until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result   <= '0;
            out_cout     <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (state == HI) begin
            if (!op_legal) begin
                out_result   <= '0;
                out_cout     <= 1'b0;
                out_zero     <= 1'b1;
                out_overflow <= 1'b0;
                out_illegal  <= 1'b1;
            end else if (op_slt) begin
                out_result   <= {{(W-1){1'b0}}, lt_hi};
                out_cout     <= 1'b0;
                out_zero     <= ~lt_hi;
                out_overflow <= 1'b0;
                out_illegal  <= 1'b0;
            end else begin
                out_result   <= {alu_result, res_lo};
                out_cout     <= op_addsub & alu_cout;
                out_zero     <= zero_lo & alu_zero;
                out_overflow <= op_addsub & alu_overflow;
                out_illegal  <= 1'b0;
            end
        end
    end

endmodule
